// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS Avalon load/store unit: op codes, FSM states
// and the request legality/alignment helpers.
package mips_lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU: bad = offset[0];
      OP_LW:         bad = (offset != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Byte-lane steering: store byteenable/replicated writedata and load-data
// extraction with sign or zero extension.
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = readdata >> {offset, 3'b000};

  always_comb begin
    byteenable = 4'b0000;
    writedata  = wdata;
    load_data  = 32'd0;
    case (op)
      OP_LB, OP_LBU: begin
        byteenable = 4'b0001 << offset;
        writedata  = {4{wdata[7:0]}};
      end
      OP_LH, OP_LHU: begin
        byteenable = 4'b0011 << offset;
        writedata  = {2{wdata[15:0]}};
      end
      OP_LW: begin
        byteenable = 4'b1111;
        writedata  = wdata;
      end
      default: begin
        byteenable = 4'b0000;
        writedata  = wdata;
      end
    endcase
    case (op)
      OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_data = {24'd0, shifted[7:0]};
      OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_data = {16'd0, shifted[15:0]};
      OP_LW:   load_data = readdata;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mips_avalon_lsu.sv
// Load/store unit: accepts one core request at a time, runs it as a single
// word-aligned Avalon-MM transfer and returns a one-cycle response.
module mips_avalon_lsu
  import mips_lsu_pkg::*;
#(
  parameter int WAIT_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_op,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [31:0]               avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [31:0]               avm_writedata,
  output logic [3:0]                avm_byteenable,
  input  logic                      avm_waitrequest,
  input  logic [31:0]               avm_readdata,
  output logic [WAIT_CNT_WIDTH-1:0] stall_cycles
);

  lsu_state_e  state, state_next;
  logic        write_q;
  logic        err_q;
  logic [2:0]  op_q;
  logic [1:0]  offset_q;
  logic [31:0] rdata_q;

  logic [2:0]  lane_op;
  logic [1:0]  lane_offset;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;
  logic        req_bad;
  logic        accept;
  logic        bus_done;

  // In IDLE the lanes look at the incoming request so the bus outputs can be
  // registered on the accept edge; afterwards they use the latched request.
  assign lane_op     = (state == ST_IDLE) ? req_op : op_q;
  assign lane_offset = (state == ST_IDLE) ? req_addr[1:0] : offset_q;

  mips_lsu_lane u_lane (
    .op         (lane_op),
    .offset     (lane_offset),
    .wdata      (req_wdata),
    .readdata   (avm_readdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .load_data  (lane_load)
  );

  assign req_bad  = !op_is_legal(req_op) || is_misaligned(req_op, req_addr[1:0]);
  assign accept   = (state == ST_IDLE) && req_valid;
  assign bus_done = (state == ST_BUS) && !avm_waitrequest;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = req_bad ? ST_RESP : ST_BUS;
      ST_BUS:  if (!avm_waitrequest) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      write_q        <= 1'b0;
      err_q          <= 1'b0;
      op_q           <= 3'd0;
      offset_q       <= 2'd0;
      rdata_q        <= 32'd0;
      avm_address    <= 32'd0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= 32'd0;
      avm_byteenable <= 4'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q  <= req_write;
        op_q     <= req_op;
        offset_q <= req_addr[1:0];
        rdata_q  <= 32'd0;
        err_q    <= req_bad;
        if (!req_bad) begin
          avm_address    <= {req_addr[31:2], 2'b00};
          avm_read       <= !req_write;
          avm_write      <= req_write;
          avm_writedata  <= lane_wdata;
          avm_byteenable <= lane_be;
        end
      end
      if (bus_done) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
        if (!write_q) rdata_q <= lane_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((avm_read || avm_write) && avm_waitrequest && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && err_q;
  assign resp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mips_avalon_lsu.sv
// Self-checking bench for mips_avalon_lsu: behavioural slave with programmable
// wait states, a byte-level memory model, directed and randomized requests.
module tb_mips_avalon_lsu;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int slv_delay = 0;
  int wcnt;
  logic [31:0] smem [16];
  logic [31:0] rmem [16];

  always #5 clk = ~clk;

  mips_avalon_lsu #(.WAIT_CNT_WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .stall_cycles    (stall_cycles)
  );

  // Slave: stalls slv_delay cycles on every access, then completes it.
  assign avm_waitrequest = (avm_read || avm_write) && (wcnt < slv_delay);
  assign avm_readdata    = smem[avm_address[5:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0;
    end else if (avm_read || avm_write) begin
      if (avm_waitrequest) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (avm_write)
          for (int i = 0; i < 4; i++)
            if (avm_byteenable[i]) smem[avm_address[5:2]][8*i +: 8] <= avm_writedata[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    if (op == 3'd2) return 4;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 1;
  endfunction

  function automatic bit model_err(input logic [2:0] op, input logic [31:0] addr);
    bit legal;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    return !legal || ((int'(addr[1:0]) % op_size(op)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] word;
    int b, h;
    word = rmem[addr[5:2]];
    b = int'((word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF);
    h = int'((word >> (8 * int'(addr[1:0]))) & 32'h0000_FFFF);
    case (op)
      3'd0: return 32'(b >= 128 ? b - 256 : b);
      3'd4: return 32'(b);
      3'd1: return 32'(h >= 32768 ? h - 65536 : h);
      3'd5: return 32'(h);
      3'd2: return word;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int o;
    o = int'(addr[1:0]);
    for (int i = 0; i < op_size(op); i++)
      rmem[addr[5:2]][8*(o+i) +: 8] = wd[8*i +: 8];
  endtask

  task automatic run_req(input bit wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int dly);
    bit err, got;
    int act, n, o, sz;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0] exp_be;
    err = model_err(op, addr);
    exp_rd = (wr || err) ? 32'd0 : model_load(op, addr);
    o = int'(addr[1:0]);
    sz = op_size(op);
    exp_be = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= o && i < o + sz) exp_be[i] = 1'b1;
    exp_wd = (sz == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
             (sz == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
    slv_delay = dly;
    @(negedge clk);
    req_write = wr; req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    act = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (avm_read || avm_write) begin
        act++;
        chk("avm_address", avm_address, {addr[31:2], 2'b00});
        if (act == 1) begin
          chk("avm_byteenable", 32'(avm_byteenable), 32'(exp_be));
          chk("avm_rw", {30'd0, avm_read, avm_write}, {30'd0, !wr, wr});
          if (wr) chk("avm_writedata", avm_writedata, exp_wd);
        end
      end
      if (resp_valid) begin
        got = 1;
        chk("resp_err", 32'(resp_err), 32'(err));
        chk("resp_rdata", resp_rdata, exp_rd);
      end else begin
        @(negedge clk);
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("bus_cycles", 32'(act), err ? 32'd0 : 32'(1 + dly));
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    if (!err) exp_stall += dly;
    if (wr && !err) model_store(op, addr, wd);
    chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
  endtask

  logic [31:0] b2b_addr [4];
  logic [2:0]  b2b_op   [4];
  logic [31:0] b2b_exp  [4];
  int          acc_t    [4];

  initial begin
    int na, nr;
    bit adv;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_op = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 16; i++) rmem[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_avm_rw", {30'd0, avm_read, avm_write}, 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_req(1'b1, 3'd2, BASE + 32'(4 * i), $urandom, 0);

    run_req(1'b1, 3'd2, BASE, 32'h1111_1111, 2);
    run_req(1'b1, 3'd0, BASE + 32'h7, 32'h0000_00AB, 0);
    run_req(1'b0, 3'd2, BASE + 32'h4, 32'd0, 1);
    run_req(1'b1, 3'd2, BASE + 32'h8, 32'h80FF_7F01, 0);
    run_req(1'b0, 3'd0, BASE + 32'hB, 32'd0, 0);
    run_req(1'b0, 3'd4, BASE + 32'hB, 32'd0, 1);
    run_req(1'b0, 3'd1, BASE + 32'hA, 32'd0, 0);
    run_req(1'b0, 3'd5, BASE + 32'h8, 32'd0, 3);
    run_req(1'b0, 3'd2, BASE + 32'h2, 32'd0, 0);
    run_req(1'b1, 3'd1, BASE + 32'h5, 32'h1234_5678, 0);
    run_req(1'b0, 3'd7, BASE + 32'h0, 32'd0, 0);

    // Reset while a read is stalled by waitrequest.
    slv_delay = 6;
    @(negedge clk);
    req_write = 1'b0; req_op = 3'd2; req_addr = BASE + 32'h10; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_avm_read", 32'(avm_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_avm_read", 32'(avm_read), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_stall = 0;
    run_req(1'b0, 3'd2, BASE + 32'h4, 32'd0, 1);

    // Back-to-back zero-wait loads with req_valid held.
    b2b_addr[0] = BASE + 32'h10; b2b_op[0] = 3'd2;
    b2b_addr[1] = BASE + 32'h17; b2b_op[1] = 3'd0;
    b2b_addr[2] = BASE + 32'h22; b2b_op[2] = 3'd5;
    b2b_addr[3] = BASE + 32'h2C; b2b_op[3] = 3'd2;
    for (int k = 0; k < 4; k++) begin
      b2b_exp[k] = model_load(b2b_op[k], b2b_addr[k]);
      acc_t[k] = 0;
    end
    slv_delay = 0;
    @(negedge clk);
    req_write = 1'b0; req_op = b2b_op[0]; req_addr = b2b_addr[0]; req_valid = 1'b1;
    na = 0; nr = 0; adv = 0;
    for (int step = 0; step < 80 && nr < 4; step++) begin
      if (adv) begin
        if (na < 4) begin req_op = b2b_op[na]; req_addr = b2b_addr[na]; end
        else req_valid = 1'b0;
        adv = 0;
      end
      if (req_ready && req_valid && na < 4) begin acc_t[na] = step; na++; adv = 1; end
      if (resp_valid && nr < 4) begin
        chk("b2b_rdata", resp_rdata, b2b_exp[nr]);
        nr++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_responses", 32'(nr), 32'd4);
    for (int k = 1; k < 4; k++) chk("b2b_spacing", 32'(acc_t[k] - acc_t[k-1]), 32'd3);
    chk("b2b_stall", 32'(stall_cycles), 32'(exp_stall));

    for (int t = 0; t < 40; t++) begin
      logic [2:0] op;
      logic [31:0] addr;
      op = 3'($urandom_range(0, 7));
      addr = BASE + 32'($urandom_range(0, 63));
      run_req(1'($urandom_range(0, 1)), op, addr, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
